// File: rtl/seq_job_ctrl.sv
// seq_job_ctrl: queues {prescaler, passes} jobs and drives the one-hot GPIO sequencer
// start/stop around each job, counting completed passes from the sequencer done level.
module seq_job_ctrl #(
  parameter int DEPTH = 4,
  parameter int PW = 14
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic                   cmd_valid_i,
  input  logic [PW-1:0]          cmd_prescaler_i,
  input  logic [3:0]             cmd_passes_i,
  output logic                   cmd_ready_o,
  input  logic                   abort_i,
  input  logic                   seq_done_i,
  output logic                   seq_start_o,
  output logic                   seq_stop_o,
  output logic [PW-1:0]          seq_prescaler_o,
  output logic                   busy_o,
  output logic                   job_done_o,
  output logic [$clog2(DEPTH):0] fifo_count_o,
  output logic                   overflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, STOP} state_e;

  state_e          state_q, state_d;
  logic [PW+3:0]   mem_q [DEPTH];
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [PW-1:0]   presc_q, presc_d, head_presc;
  logic [3:0]      head_pass;
  logic [4:0]      rem_q, rem_d;
  logic            done_q, job_done_q, job_done_d, ovf_q, ovf_d;
  logic            push, pop, done_rise;

  assign {head_presc, head_pass} = mem_q[rd_q];
  assign cmd_ready_o     = cnt_q != FULL;
  // abort wins over a same-cycle push and never counts as an overflow
  assign push            = cmd_valid_i & cmd_ready_o & ~abort_i;
  assign pop             = (state_q == IDLE) & en_i & (cnt_q != '0) & ~abort_i;
  assign done_rise       = seq_done_i & ~done_q;
  assign seq_start_o     = state_q == START;
  assign seq_stop_o      = state_q == STOP;
  assign busy_o          = state_q != IDLE;
  assign job_done_o      = job_done_q;
  assign seq_prescaler_o = presc_q;
  assign fifo_count_o    = cnt_q;
  assign overflow_o      = ovf_q;

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    rem_d      = rem_q;
    job_done_d = 1'b0;
    wr_d       = abort_i ? '0 : wr_q + AW'(push);
    rd_d       = abort_i ? '0 : rd_q + AW'(pop);
    cnt_d      = abort_i ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    ovf_d      = ovf_q | (cmd_valid_i & ~cmd_ready_o & ~abort_i);
    case (state_q)
      IDLE: if (pop) begin
        state_d = LOAD;
        presc_d = head_presc;
        rem_d   = (head_pass == 4'd0) ? 5'd16 : {1'b0, head_pass};
      end
      LOAD:  state_d = abort_i ? STOP : START;
      START: state_d = abort_i ? STOP : RUN;
      RUN: if (abort_i) state_d = STOP;
        else if (done_rise) begin
          rem_d = rem_q - 5'd1;
          if (rem_q == 5'd1) begin
            state_d    = STOP;
            job_done_d = 1'b1;
          end
        end
      STOP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i)
    if (push) mem_q[wr_q] <= {cmd_prescaler_i, cmd_passes_i};

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q    <= IDLE;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      presc_q    <= '0;
      rem_q      <= '0;
      done_q     <= 1'b0;
      job_done_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      presc_q    <= presc_d;
      rem_q      <= rem_d;
      done_q     <= seq_done_i;
      job_done_q <= job_done_d;
      ovf_q      <= ovf_d;
    end
endmodule

// File: tb/tb_seq_job_ctrl.sv
// tb_seq_job_ctrl: vector table, directed multi-cycle sequences with a stub sequencer,
// then random traffic compared against a queue-based job model.
`timescale 1ns/1ps
module tb_seq_job_ctrl;
  localparam int PW = 14;
  localparam int DEPTH = 4;

  typedef struct {
    logic en, valid; logic [PW-1:0] p; logic [3:0] n; logic ab, dn;
    logic start, stop, busy, jd, ready, ovf; logic [2:0] cnt; logic [PW-1:0] presc;
  } vec_t;
  typedef struct { logic [PW-1:0] p; logic [3:0] n; } job_t;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, cmd_valid = 1'b0, abort = 1'b0;
  logic done_r = 1'b0, stub_en = 1'b0, stub_run = 1'b0;
  logic [PW-1:0] cmd_presc = '0, seq_presc;
  logic [3:0] cmd_passes = '0;
  logic cmd_ready, seq_start, seq_stop, busy, job_done, overflow, seq_done, stub_done;
  logic [2:0] fifo_count;
  int stub_cnt = 0, stub_p = 35;
  int n_cmp = 0, n_err = 0;
  int starts, jds, order_bad, ovf_drop;
  bit seen;
  vec_t tbl [17];

  job_t mq[$];
  bit m_ovf, m_has, m_stop, m_fin, m_prev;
  int m_age, m_left;
  logic [PW-1:0] m_presc;

  seq_job_ctrl #(.DEPTH(DEPTH), .PW(PW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .cmd_valid_i(cmd_valid),
    .cmd_prescaler_i(cmd_presc), .cmd_passes_i(cmd_passes), .cmd_ready_o(cmd_ready),
    .abort_i(abort), .seq_done_i(seq_done), .seq_start_o(seq_start), .seq_stop_o(seq_stop),
    .seq_prescaler_o(seq_presc), .busy_o(busy), .job_done_o(job_done),
    .fifo_count_o(fifo_count), .overflow_o(overflow)
  );

  always #50 clk = ~clk;

  // stub sequencer: one done cycle every stub_p cycles after a start, until stopped
  always @(negedge clk)
    if (!rst_n) stub_run <= 1'b0;
    else if (seq_start) begin stub_run <= 1'b1; stub_cnt <= 0; end
    else if (seq_stop) stub_run <= 1'b0;
    else if (stub_run) stub_cnt <= (stub_cnt == stub_p - 1) ? 0 : stub_cnt + 1;
  assign stub_done = stub_run && (stub_cnt == stub_p - 1);
  assign seq_done = stub_en ? stub_done : done_r;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, " start"}, seq_start, 0); chk({nm, " stop"}, seq_stop, 0);
    chk({nm, " busy"}, busy, 0); chk({nm, " job_done"}, job_done, 0);
    chk({nm, " overflow"}, overflow, 0); chk({nm, " presc"}, seq_presc, 0);
    chk({nm, " count"}, fifo_count, 0); chk({nm, " ready"}, cmd_ready, 1);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; cmd_valid = 1'b0; abort = 1'b0; en = 1'b0; done_r = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [PW-1:0] p, input logic [3:0] n);
    cmd_valid = 1'b1; cmd_presc = p; cmd_passes = n;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_start(input string nm, input int limit);
    seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      seen = seq_start;
    end
    chk({nm, " seq_start seen"}, seen, 1);
  endtask

  task automatic run_one(input logic [PW-1:0] p, input logic [3:0] n, input int exp_rises);
    int rises = 0, bad_p = 0;
    bit done_seen = 0, prev = 0;
    reset_dut();
    stub_en = 1'b1; stub_p = 35; en = 1'b1;
    push(p, n);
    @(negedge clk); chk("job load busy", busy, 1);
    @(negedge clk); chk("job start latency", seq_start, 1);
    for (int i = 0; i < exp_rises * 35 + 200 && !done_seen; i++) begin
      @(negedge clk);
      if (seq_presc !== p) bad_p++;
      if (seq_done && !prev) rises++;
      prev = seq_done;
      if (job_done) begin
        done_seen = 1;
        chk("job stop with job_done", seq_stop, 1);
      end
    end
    chk("job job_done seen", done_seen, 1);
    chk("job done rises", rises, exp_rises);
    chk("job presc held", bad_p, 0);
    @(negedge clk); chk("job busy falls", busy, 0);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_has = 0; m_stop = 0; m_fin = 0; m_prev = 0; m_age = 0; m_left = 0; m_presc = '0;
  endtask

  // one clock edge of the job-level model: a job is pending, launched, running or ending
  task automatic model_step();
    bit rise;
    int sz;
    job_t j;
    rise = seq_done && !m_prev;
    m_prev = seq_done;
    sz = mq.size();
    if (m_stop) begin
      m_stop = 0; m_fin = 0;
    end else if (m_has) begin
      if (abort) begin
        m_has = 0; m_stop = 1; m_fin = 0;
      end else if (m_age >= 2 && rise) begin
        m_left--;
        if (m_left == 0) begin m_has = 0; m_stop = 1; m_fin = 1; end
      end
      if (m_has) m_age++;
    end else if (en && sz != 0 && !abort) begin
      j = mq.pop_front();
      m_presc = j.p;
      m_left = (j.n == 0) ? 16 : int'(j.n);
      m_has = 1; m_age = 0;
    end
    if (abort) mq.delete();
    else if (cmd_valid) begin
      if (sz < DEPTH) begin j.p = cmd_presc; j.n = cmd_passes; mq.push_back(j); end
      else m_ovf = 1;
    end
  endtask

  task automatic model_compare();
    chk("rnd busy", busy, (m_has || m_stop) ? 1 : 0);
    chk("rnd start", seq_start, (m_has && m_age == 1) ? 1 : 0);
    chk("rnd stop", seq_stop, m_stop ? 1 : 0);
    chk("rnd job_done", job_done, (m_stop && m_fin) ? 1 : 0);
    chk("rnd count", fifo_count, mq.size());
    chk("rnd ready", cmd_ready, (mq.size() < DEPTH) ? 1 : 0);
    chk("rnd overflow", overflow, m_ovf ? 1 : 0);
    chk("rnd presc", seq_presc, m_presc);
  endtask

  initial begin
    tbl[0]  = '{1,1,1,2,0,0, 0,0,0,0,1,0,1,0};
    tbl[1]  = '{1,0,0,0,0,0, 0,0,1,0,1,0,0,1};
    tbl[2]  = '{1,0,0,0,0,0, 1,0,1,0,1,0,0,1};
    tbl[3]  = '{1,0,0,0,0,1, 0,0,1,0,1,0,0,1};
    tbl[4]  = '{1,0,0,0,0,0, 0,0,1,0,1,0,0,1};
    tbl[5]  = '{1,0,0,0,0,1, 0,0,1,0,1,0,0,1};
    tbl[6]  = '{1,0,0,0,0,1, 0,0,1,0,1,0,0,1};
    tbl[7]  = '{1,0,0,0,0,0, 0,0,1,0,1,0,0,1};
    tbl[8]  = '{1,0,0,0,0,1, 0,1,1,1,1,0,0,1};
    tbl[9]  = '{1,0,0,0,0,0, 0,0,0,0,1,0,0,1};
    tbl[10] = '{0,1,1,1,0,0, 0,0,0,0,1,0,1,1};
    tbl[11] = '{0,1,2,1,0,0, 0,0,0,0,1,0,2,1};
    tbl[12] = '{0,1,3,1,0,0, 0,0,0,0,1,0,3,1};
    tbl[13] = '{0,1,4,1,0,0, 0,0,0,0,0,0,4,1};
    tbl[14] = '{0,1,5,1,1,0, 0,0,0,0,1,0,0,1};
    tbl[15] = '{0,1,6,1,0,0, 0,0,0,0,1,0,1,1};
    tbl[16] = '{0,0,0,0,1,0, 0,0,0,0,1,0,0,1};

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("in reset");
    rst_n = 1'b1;
    #1 chk_reset_vals("after reset");

    for (int i = 0; i < 17; i++) begin
      en = tbl[i].en; cmd_valid = tbl[i].valid; cmd_presc = tbl[i].p;
      cmd_passes = tbl[i].n; abort = tbl[i].ab; done_r = tbl[i].dn;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("row%0d start", i), seq_start, tbl[i].start);
      chk($sformatf("row%0d stop", i), seq_stop, tbl[i].stop);
      chk($sformatf("row%0d busy", i), busy, tbl[i].busy);
      chk($sformatf("row%0d job_done", i), job_done, tbl[i].jd);
      chk($sformatf("row%0d ready", i), cmd_ready, tbl[i].ready);
      chk($sformatf("row%0d overflow", i), overflow, tbl[i].ovf);
      chk($sformatf("row%0d count", i), fifo_count, tbl[i].cnt);
      chk($sformatf("row%0d presc", i), seq_presc, tbl[i].presc);
    end
    cmd_valid = 1'b0; abort = 1'b0; done_r = 1'b0;

    run_one(14'd1, 4'd2, 2);
    run_one(14'd10, 4'd0, 16);

    reset_dut();
    stub_en = 1'b1; stub_p = 5;
    for (int k = 1; k <= 5; k++) push(PW'(k), 4'd1);
    chk("full count", fifo_count, 4);
    chk("full ready", cmd_ready, 0);
    chk("full overflow", overflow, 1);
    en = 1'b1; starts = 0; jds = 0; order_bad = 0; ovf_drop = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (seq_start) begin
        starts++;
        if (seq_presc !== PW'(starts)) order_bad++;
      end
      if (job_done) jds++;
      if (overflow !== 1'b1) ovf_drop++;
    end
    chk("queue starts", starts, 4);
    chk("queue order", order_bad, 0);
    chk("queue job_dones", jds, 4);
    chk("queue overflow sticky", ovf_drop, 0);
    chk("queue idle", busy, 0);

    reset_dut();
    stub_en = 1'b1; stub_p = 35;
    push(14'd5, 4'd3); push(14'd6, 4'd3);
    en = 1'b1;
    wait_start("abort", 10);
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort stop", seq_stop, 1);
    chk("abort no job_done", job_done, 0);
    chk("abort flush", fifo_count, 0);
    starts = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (seq_start) starts++;
    end
    chk("abort no restart", starts, 0);
    chk("abort idle", busy, 0);

    reset_dut();
    stub_en = 1'b1; stub_p = 5;
    push(14'd7, 4'd2); push(14'd8, 4'd1);
    en = 1'b1;
    wait_start("en drop", 10);
    en = 1'b0;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = job_done;
    end
    chk("en drop job_done", seen, 1);
    starts = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (seq_start) starts++;
    end
    chk("en drop held", starts, 0);
    chk("en drop idle", busy, 0);
    chk("en drop queued", fifo_count, 1);
    en = 1'b1;
    wait_start("en resume", 10);
    chk("en resume presc", seq_presc, 8);

    reset_dut();
    stub_en = 1'b1; stub_p = 35;
    for (int k = 1; k <= 5; k++) push(PW'(k + 20), 4'd2);
    en = 1'b1;
    wait_start("mid reset", 10);
    repeat (3) @(negedge clk);
    #20 rst_n = 1'b0;
    #1 chk_reset_vals("async reset");
    @(negedge clk);
    rst_n = 1'b1;

    reset_dut();
    stub_en = 1'b0;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      model_compare();
      en = (((c / 200) % 2) == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
      cmd_valid = $urandom_range(0, 2) == 0;
      cmd_presc = PW'($urandom);
      cmd_passes = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 3));
      abort = $urandom_range(0, 59) == 0;
      done_r = $urandom_range(0, 2) == 0;
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
    model_compare();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/seq_job_ctrl.md
# seq_job_ctrl

Job scheduler that sits in front of the GPIO one-hot sequencer, which walks a single high bit across the 34 GPIO outputs. The block queues up to DEPTH sequence jobs, each a prescaler value plus a pass count. It starts the sequencer for each job, counts completed passes via the sequencer's done flag, and then stops the sequencer. This lets firmware over the logic analyzer (LA) interface or a GPIO host queue several timed sweeps without babysitting each one.

## Interface
- DEPTH, 4, job FIFO entries (power of two, ≥2)
- PW, 14, prescaler width (matches sequencer prescaler port)
- clk  in  1  system clock, 10 MHz
- nrst  in  1  asynchronous active-low reset
- en  in  1  gates launching of new jobs; an active job continues when en falls
- cmd_valid  in  1  job push request
- cmd_prescaler  in  PW  job prescaler, in ms per GPIO step
- cmd_passes  in  4  full 34-step passes to run; 0 encodes 16
- cmd_ready  out  1  FIFO can accept a push (count < DEPTH)
- abort  in  1  stop the current job and flush the FIFO
- seq_done  in  1  sequencer done level (high while GPIO[33] is the active bit)
- seq_start  out  1  one-cycle start pulse to the sequencer
- seq_stop  out  1  one-cycle stop pulse to the sequencer
- seq_prescaler  out  PW  prescaler to the sequencer; held for the whole job
- busy  out  1  a job is loaded or running
- job_done  out  1  one-cycle pulse when a job finishes normally
- fifo_count  out  $clog2(DEPTH)+1  jobs queued, excluding the active job
- overflow  out  1  sticky; set when cmd_valid arrives while cmd_ready=0

## Operation
- FIFO: push on cmd_valid & cmd_ready. Pop occurs only in the LOAD transition. Push and pop in the same cycle leave the count unchanged. A push while full is dropped and sets overflow.
- Job registers: presc_q (PW bits) and remaining (5 bits). At pop, remaining = (passes==0) ? 16 : passes.
- Done edge: done_d is a registered copy of seq_done. done_rise = seq_done & ~done_d.
- States are Moore and registered: IDLE, LOAD, START, RUN, STOP.
- IDLE → LOAD when en & fifo_count≠0. LOAD pops the head into the job registers.
- LOAD → START unconditionally.
- START drives seq_start=1, then → RUN.
- RUN: on done_rise, remaining decrements. If it reaches 0, → STOP with job_done asserted in the STOP cycle. Otherwise stay in RUN; the sequencer wraps by itself.
- STOP drives seq_stop=1, then → IDLE. The next job can enter LOAD on the following edge.
- Abort from LOAD, START or RUN → STOP next edge, with no job_done. The FIFO is flushed to count 0 on that same edge. Abort in IDLE only flushes. Abort overrides a same-cycle push (the push is dropped; overflow is not set).
- done_rise is ignored outside RUN. A done_rise in the START cycle is not counted.
- busy = (state≠IDLE). seq_prescaler = presc_q in every state, so it stays stable between jobs.

## Timing
- Reset values: state IDLE; seq_start, seq_stop, job_done, busy and overflow all 0. seq_prescaler 0; fifo_count 0; cmd_ready 1; FIFO pointers 0; done_d 0.
- Reset mid-job returns all outputs to reset values immediately (asynchronous). The queued jobs are lost.
- Push at edge E0 into an empty FIFO while IDLE with en=1:
  - E1: LOAD, fifo_count back to 0.
  - E2: START, seq_start high E2→E3.
  - E3: RUN.
- Pass counting: the done_rise sampled at edge Ek decrements remaining at Ek. Final pass: STOP from Ek to Ek+1, with seq_stop and job_done both high for that one cycle.
- Back-to-back jobs: at most 3 idle cycles (STOP, IDLE, LOAD) between the last done_rise of one job and seq_start of the next.
- Sample outputs away from the rising edge of clk.

## Test plan
- Reset: hold nrst=0 for 2 cycles, release at negedge → all outputs at reset values, cmd_ready=1.
- Single job, 2 passes: push {prescaler=1, passes=2} with a stub sequencer giving done every 35 cycles, en=1.
  - seq_start pulses 2 cycles after the push.
  - seq_prescaler=1 throughout.
  - Exactly 2 done_rises counted; seq_stop and job_done pulse together one cycle after the 2nd rise; busy falls the cycle after that.
- Queue and full: with en=0, push 5 jobs with DEPTH=4.
  - After 4 pushes, fifo_count=4 and cmd_ready=0; the 5th push sets overflow=1.
  - Raise en → jobs run in order with prescalers 1, 2, 3, 4.
  - overflow stays 1 until reset.
- passes=0: push {10, 0} → 16 done_rises before job_done; seq_prescaler=10 throughout.
- Abort mid-run: 2 jobs queued; during pass 1 of job 1, pulse abort.
  - Next cycle: seq_stop=1, job_done=0, fifo_count=0.
  - IDLE is reached with no further seq_start.
- en drop mid-job: deassert en during RUN → current job completes normally with job_done. The queued job does not launch until en=1.
